// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: screen geometry, LFSR constants, flake record and update FSM states.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned LFSR_W   = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] WIND_RIGHT = 2'b01;
  localparam logic [1:0] WIND_LEFT  = 2'b10;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               spd;
  } flake_t;

  typedef enum logic {
    IDLE,
    UPD
  } upd_state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; seed and taps come from vga_pkg.
module lfsr16
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

endmodule

// File: rtl/snow_field.sv
// Snowfall overlay: a flake table advanced once per frame in vertical blanking,
// plus a registered per-pixel hit test against every active flake.
module snow_field #(
  parameter int unsigned NUM_FLAKES = 16,
  parameter int unsigned FLAKE_SIZE = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned SPAWN_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       snow_en,
  input  logic [1:0] wind,
  input  logic       v_sync,
  input  logic       req,
  input  logic [9:0] col,
  input  logic [9:0] row,
  output logic       snow_hit,
  output logic       busy
);

  import vga_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_FLAKES);
  localparam int unsigned FOLD  = 1024 - H_ACTIVE;
  localparam logic [4:0]  SPAWN_MASK = 5'((32'd1 << SPAWN_BITS) - 32'd1);

  logic [LFSR_W-1:0] lfsr;
  logic              sync_q1, sync_q2;
  logic              v_sync_q;
  logic              spawn_ok;
  logic              spawned;
  upd_state_t        state;
  logic [IDX_W-1:0]  idx;
  flake_t            flakes [NUM_FLAKES];

  flake_t            cur_c, nxt_c;
  logic              spawn_c;
  logic [10:0]       y_sum_c;
  logic              hit_c;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Next value of the entry currently being visited by the update walk.
  always_comb begin
    cur_c   = flakes[idx];
    nxt_c   = cur_c;
    spawn_c = 1'b0;
    y_sum_c = 11'(cur_c.y) + 11'(cur_c.spd) + 11'd1;
    if (cur_c.active) begin
      if (y_sum_c >= 11'(V_ACTIVE)) begin
        nxt_c.active = 1'b0;
      end else begin
        nxt_c.y = y_sum_c[9:0];
      end
      case (wind)
        WIND_RIGHT: nxt_c.x = (cur_c.x == 10'(H_ACTIVE - 1)) ? 10'd0 : cur_c.x + 10'd1;
        WIND_LEFT:  nxt_c.x = (cur_c.x == 10'd0) ? 10'(H_ACTIVE - 1) : cur_c.x - 10'd1;
        default:    nxt_c.x = cur_c.x;
      endcase
    end else if (spawn_ok && !spawned && ((lfsr[14:10] & SPAWN_MASK) == 5'd0)) begin
      spawn_c      = 1'b1;
      nxt_c.active = 1'b1;
      nxt_c.y      = 10'd0;
      nxt_c.spd    = lfsr[15];
      nxt_c.x      = (lfsr[9:0] < 10'(H_ACTIVE)) ? lfsr[9:0] : lfsr[9:0] - 10'(FOLD);
    end
  end

  // OR-tree hit test; 11-bit sums keep flakes at the right/bottom edge from wrapping.
  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < NUM_FLAKES; i++) begin
      if (flakes[i].active &&
          (11'(col) >= 11'(flakes[i].x)) &&
          (11'(col) <= 11'(flakes[i].x) + 11'(FLAKE_SIZE - 1)) &&
          (11'(row) >= 11'(flakes[i].y)) &&
          (11'(row) <= 11'(flakes[i].y) + 11'(FLAKE_SIZE - 1))) begin
        hit_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      v_sync_q <= 1'b1;
      snow_hit <= 1'b0;
      busy     <= 1'b0;
      spawn_ok <= 1'b0;
      spawned  <= 1'b0;
      idx      <= '0;
      state    <= IDLE;
      for (int i = 0; i < NUM_FLAKES; i++) begin
        flakes[i] <= '0;
      end
    end else begin
      sync_q1  <= snow_en;
      sync_q2  <= sync_q1;
      v_sync_q <= v_sync;
      snow_hit <= req & hit_c;
      case (state)
        IDLE: begin
          if (v_sync_q && !v_sync) begin
            state    <= UPD;
            idx      <= '0;
            spawned  <= 1'b0;
            spawn_ok <= sync_q2;
            busy     <= 1'b1;
          end
        end
        UPD: begin
          flakes[idx] <= nxt_c;
          if (spawn_c) begin
            spawned <= 1'b1;
          end
          if (idx == IDX_W'(NUM_FLAKES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow_field.sv
// Directed bench for snow_field: reset, spawn, fall/retire, wind wrap, hit window, reset mid-update.
module tb_snow_field;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       snow_en;
  logic [1:0] wind;
  logic       v_sync;
  logic       req;
  logic [9:0] col;
  logic [9:0] row;
  logic       snow_hit;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;
  flake_t      model [16];
  int          fk;
  logic [15:0] fraw;
  int          frames;
  logic        hit_done;

  snow_field dut (
    .clk      (clk),
    .rst      (rst),
    .snow_en  (snow_en),
    .wind     (wind),
    .v_sync   (v_sync),
    .req      (req),
    .col      (col),
    .row      (row),
    .snow_hit (snow_hit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic flake_t step_entry(input flake_t e, input logic [15:0] l, input logic [1:0] w,
                                        input logic ok, input logic sp_in, output logic sp_out);
    flake_t r = e;
    int     yn;
    sp_out = sp_in;
    if (e.active) begin
      yn = int'(e.y) + int'(e.spd) + 1;
      if (yn >= 480) r.active = 1'b0;
      else           r.y = 10'(yn);
      if (w == 2'b01)      r.x = (e.x == 10'd639) ? 10'd0 : 10'(e.x + 10'd1);
      else if (w == 2'b10) r.x = (e.x == 10'd0) ? 10'd639 : 10'(e.x - 10'd1);
    end else if (ok && !sp_in && l[13:10] == 4'd0) begin
      r.active = 1'b1;
      r.y      = 10'd0;
      r.spd    = l[15];
      r.x      = (l[9:0] >= 10'd640) ? 10'(l[9:0] - 10'd384) : l[9:0];
      sp_out   = 1'b1;
    end
    return r;
  endfunction

  // Index of the slot that would spawn if an update were triggered now, or -1.
  function automatic int predict(input logic [15:0] l0, output logic [15:0] raw);
    logic [15:0] s = l0;
    raw = '0;
    for (int k = 0; k < 16; k++) begin
      s = lfsr_step(s);
      if (!model[k].active && s[13:10] == 4'd0) begin
        raw = s;
        return k;
      end
    end
    return -1;
  endfunction

  function automatic int active_cnt();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(dut.flakes[i].active);
    return c;
  endfunction

  // Called just after a negedge: pulse v_sync low, walk the model alongside the DUT.
  task automatic run_frame(input logic glitch);
    logic ok = snow_en;
    logic spawned = 1'b0;
    logic sp_out;
    int   busy_cnt = 0;
    v_sync = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) v_sync = 1'b1;
      if (glitch && k == 4) v_sync = 1'b0;
      if (glitch && k == 5) v_sync = 1'b1;
      if (busy) busy_cnt++;
      model[k] = step_entry(model[k], m_lfsr, wind, ok, spawned, sp_out);
      spawned  = sp_out;
    end
    @(negedge clk);
    check_eq("busy_len", 32'(busy_cnt), 32'd16);
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("flake%0d", i), 32'(dut.flakes[i]), 32'(model[i]));
  endtask

  task automatic wait_spawn(input logic need_fold, output int k, output logic [15:0] raw);
    int tries = 0;
    k = -1;
    while (tries < 20000) begin
      k = predict(m_lfsr, raw);
      if (k >= 0 && (!need_fold || (raw[15] && raw[9:0] >= 10'd834))) break;
      k = -1;
      @(negedge clk);
      tries++;
    end
    check_eq("spawn_search", 32'(k >= 0), 32'd1);
  endtask

  task automatic probe(input string tag, input logic r, input logic [9:0] c, input logic [9:0] w,
                       input logic exp);
    @(negedge clk);
    req = r;
    col = c;
    row = w;
    @(negedge clk);
    check_eq(tag, 32'(snow_hit), 32'(exp));
    req = 1'b0;
  endtask

  task automatic maybe_hit();
    logic [9:0] x, y;
    if (!hit_done && model[fk].active && model[fk].y == 10'd50) begin
      x = model[fk].x;
      y = model[fk].y;
      probe("hit_origin", 1'b1, x, y, 1'b1);
      probe("hit_far",    1'b1, 10'(x + 10'd3), 10'(y + 10'd3), 1'b1);
      probe("miss_right", 1'b1, 10'(x + 10'd4), y, 1'b0);
      probe("miss_below", 1'b1, x, 10'(y + 10'd4), 1'b0);
      probe("miss_noreq", 1'b0, x, y, 1'b0);
      hit_done = 1'b1;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; snow_en = 1'b0; wind = 2'b00; v_sync = 1'b1;
    req = 1'b1; col = '0; row = '0; hit_done = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_hit", 32'(snow_hit), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    #1;
    check_eq("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    @(negedge clk);
    check_eq("post_rst_hit", 32'(snow_hit), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    req = 1'b0;

    // No snow button, extra v_sync edge during the walk
    @(negedge clk);
    run_frame(1'b1);
    check_eq("idle_count", 32'(active_cnt()), 32'd0);

    // Spawn a fast flake with a folded x coordinate
    snow_en = 1'b1;
    repeat (4) @(negedge clk);
    wait_spawn(1'b1, fk, fraw);
    if (fk < 0) begin
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "no spawn opportunity");
    end
    run_frame(1'b0);
    check_eq("spawn_count", 32'(active_cnt()), 32'd1);
    check_eq("spawn_x", 32'(dut.flakes[fk].x), 32'(fraw[9:0] - 10'd384));
    check_eq("spawn_spd", 32'(dut.flakes[fk].spd), 32'd1);
    snow_en = 1'b0;
    repeat (4) @(negedge clk);

    // Drift right to the edge, wrap both ways
    wind = 2'b01;
    frames = 0;
    while (model[fk].x != 10'd639 && frames < 400) begin
      maybe_hit();
      @(negedge clk);
      run_frame(1'b0);
      frames++;
    end
    @(negedge clk);
    run_frame(1'b0);
    check_eq("wrap_plus", 32'(dut.flakes[fk].x), 32'd0);
    wind = 2'b10;
    @(negedge clk);
    run_frame(1'b0);
    check_eq("wrap_minus", 32'(dut.flakes[fk].x), 32'd639);
    wind = 2'b00;

    // Fall to the bottom and retire
    while (model[fk].y != 10'd478 && frames < 400) begin
      maybe_hit();
      @(negedge clk);
      run_frame(1'b0);
      frames++;
    end
    check_eq("hit_done", 32'(hit_done), 32'd1);
    check_eq("pre_retire_y", 32'(dut.flakes[fk].y), 32'd478);
    check_eq("pre_retire_act", 32'(dut.flakes[fk].active), 32'd1);
    @(negedge clk);
    run_frame(1'b0);
    check_eq("retire", 32'(dut.flakes[fk].active), 32'd0);
    @(negedge clk);
    run_frame(1'b0);
    check_eq("no_respawn", 32'(active_cnt()), 32'd0);

    // Reset in the middle of an update
    snow_en = 1'b1;
    repeat (4) @(negedge clk);
    wait_spawn(1'b0, fk, fraw);
    run_frame(1'b0);
    snow_en = 1'b0;
    check_eq("mid_pre_count", 32'(active_cnt()), 32'd1);
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
    v_sync = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_count", 32'(active_cnt()), 32'd0);
    check_eq("mid_hit", 32'(snow_hit), 32'd0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
